ram_banked_clr: RTL and testbench

//  Parametrised banked single-port RAM; successor to the fixed 16-bit x 512 word RAM.

---
 rtl/ram_banked_clr_pkg.sv | 26 ++
 rtl/ram_banked_clr_bank.sv | 29 ++
 rtl/ram_banked_clr.sv | 125 ++++++++++++
 tb/tb_ram_banked_clr.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ram_banked_clr_pkg.sv
// Shared definitions for the banked RAM with hardware clear sweep:
// FSM state encodings and default geometry for the 16-bit x 512 word part.
`ifndef RAM_BANKED_CLR_PKG_SV
`define RAM_BANKED_CLR_PKG_SV

package ram_banked_clr_pkg;

  // Default geometry: 16-bit words, 512 words, 8 banks of 64 words.
  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_ADDR_BITS = 9;
  localparam int DEFAULT_BANK_BITS = 3;

  // CLEAR: sweep zeroing all banks in parallel; READY: normal CPU access.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // True when the bank split leaves at least one bank bit and one word bit.
  function automatic bit bank_bits_legal(input int addr_bits, input int bank_bits);
    return (bank_bits >= 1) && (bank_bits <= addr_bits - 1);
  endfunction

endpackage

`endif

// File: rtl/ram_banked_clr_bank.sv
// One single-port RAM bank: synchronous write, registered read-first output.
// Written so that synthesis maps it onto a block RAM.
module ram_banked_clr_bank #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Write when enabled; the read register samples the old word (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_banked_clr.sv
// Banked single-port RAM with a hardware clear sweep after reset.
// Reset starts a sweep that zeroes one word per bank per cycle, all banks in
// parallel; busy stays high until the sweep finishes and user loads are ignored
// meanwhile. Read data is registered, with one cycle of latency.
module ram_banked_clr
  import ram_banked_clr_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int BANK_BITS = DEFAULT_BANK_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int WORD_BITS  = ADDR_BITS - BANK_BITS;
  localparam int NUM_BANKS  = 1 << BANK_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

  // Elaboration-time guard against an illegal bank split.
  if (!bank_bits_legal(ADDR_BITS, BANK_BITS)) begin : g_bad_geometry
    $error("ram_banked_clr: BANK_BITS must be in 1..ADDR_BITS-1");
  end

  state_t                 state_reg;
  state_t                 state_next;
  logic [WORD_BITS-1:0]   clr_addr_reg;
  logic                   clearing;
  logic                   user_access;

  logic [BANK_BITS-1:0]   bank_sel;
  logic [BANK_BITS-1:0]   bank_sel_reg;
  logic [WORD_BITS-1:0]   word_addr;
  logic [WORD_BITS-1:0]   bank_addr;
  logic [WIDTH-1:0]       bank_wdata;
  logic [NUM_BANKS-1:0]   bank_we;
  logic [WIDTH-1:0]       bank_rdata [NUM_BANKS];
  logic                   rd_valid_reg;

  assign bank_sel  = address[ADDR_BITS-1 -: BANK_BITS];
  assign word_addr = address[WORD_BITS-1:0];

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave CLEAR once the last word of every bank has been zeroed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR: if (clr_addr_reg == LAST_WORD) state_next = READY;
      READY: state_next = READY;
    endcase
  end

  // FSM outputs: busy follows state alone; writes are suppressed while reset is held.
  always_comb begin
    busy        = (state_reg == CLEAR);
    clearing    = (state_reg == CLEAR) && !reset;
    user_access = (state_reg == READY) && !reset;
  end

  // Clear counter: restarts on reset and parks on the last word instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr_reg <= '0;
    end else if (state_reg == CLEAR && clr_addr_reg != LAST_WORD) begin
      clr_addr_reg <= clr_addr_reg + WORD_BITS'(1);
    end
  end

  // Write mux: the sweep owns every bank's address and data port while clearing.
  always_comb begin
    bank_addr  = word_addr;
    bank_wdata = in;
    if (clearing) begin
      bank_addr  = clr_addr_reg;
      bank_wdata = '0;
    end
  end

  // Bank select and read-valid flag registered alongside the bank read data,
  // so out has no combinational path from address.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      bank_sel_reg <= bank_sel;
      rd_valid_reg <= (state_reg == READY);
    end
  end

  // Write-enable decode and bank array: all banks during the sweep, else only
  // the addressed bank when load is asserted.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_we[gi] = clearing ||
                         (user_access && load && (bank_sel == BANK_BITS'(gi)));

    ram_banked_clr_bank #(
      .WIDTH      (WIDTH),
      .DEPTH_BITS (WORD_BITS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[gi]),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[gi])
    );
  end

  // Output mux: forced to zero until a read issued in READY has completed.
  assign out = rd_valid_reg ? bank_rdata[bank_sel_reg] : '0;

endmodule

// File: tb/tb_ram_banked_clr.sv
// Directed self-checking bench for ram_banked_clr at default geometry
// (16-bit words, 512 words, 8 banks of 64).
module tb_ram_banked_clr;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic [8:0]  address;
  logic        load;
  logic [15:0] out;
  logic        busy;

  int total;
  int passed;

  ram_banked_clr #(
    .WIDTH     (16),
    .ADDR_BITS (9),
    .BANK_BITS (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .address (address),
    .load    (load),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports on mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold reset across one rising edge, release it; returns at the sample point after that edge.
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Count samples with busy high (bounded), noting any nonzero out meanwhile.
  task automatic wait_ready(output int n, output bit out_nz);
    n      = 0;
    out_nz = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (out !== 16'h0000) out_nz = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic write_word(input logic [8:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] a, output logic [15:0] d);
    address = a;
    load    = 1'b0;
    @(negedge clk);
    d = out;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          out_nz;
    logic [15:0] rd;

    total   = 0;
    passed  = 0;
    reset   = 1'b1;
    load    = 1'b0;
    in      = 16'h0000;
    address = 9'h000;

    // Reset state after two edges with reset held.
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);

    // 1: busy for exactly 64 cycles after release, out zero throughout.
    reset = 1'b0;
    wait_ready(n, out_nz);
    $display("sweep1: busy cycles %0d", n);
    chk("t1_busy_len", 32'(n), 32'd64);
    chk("t1_out_zero_during", 32'(out_nz), 32'h0);
    chk("t1_out_after", 32'(out), 32'h0);
    chk("t1_busy_low", 32'(busy), 32'h0);

    // 2: write then read back with one cycle of latency.
    write_word(9'h1C5, 16'hBEEF);
    read_word(9'h1C5, rd);
    $display("t2: read 1C5 -> %h", rd);
    chk("t2_read_1C5", 32'(rd), 32'hBEEF);

    // 3: read-during-write returns old word, new word on the next read.
    write_word(9'h010, 16'h1111);
    address = 9'h010;
    in      = 16'h2222;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    $display("t3: rdw 010 -> %h", out);
    chk("t3_read_first", 32'(out), 32'h1111);
    read_word(9'h010, rd);
    $display("t3: read 010 -> %h", rd);
    chk("t3_new_word", 32'(rd), 32'h2222);

    // Previously written word still intact.
    read_word(9'h1C5, rd);
    chk("t3_1C5_kept", 32'(rd), 32'hBEEF);

    // 4: load during the sweep (cycle 10) is ignored.
    do_reset();
    chk("t4_out_zero_reset", 32'(out), 32'h0);
    repeat (10) @(negedge clk);
    write_word(9'h005, 16'hAAAA);
    chk("t4_busy_mid", 32'(busy), 32'h1);
    wait_ready(n, out_nz);
    chk("t4_out_zero_during", 32'(out_nz), 32'h0);
    read_word(9'h005, rd);
    $display("t4: read 005 -> %h", rd);
    chk("t4_ignored_load", 32'(rd), 32'h0000);
    read_word(9'h1C5, rd);
    chk("t4_1C5_cleared", 32'(rd), 32'h0000);

    // 5: reset mid-sweep restarts the full sweep.
    write_word(9'h03F, 16'h1234);
    write_word(9'h040, 16'h1234);
    write_word(9'h1FF, 16'h1234);
    read_word(9'h1FF, rd);
    chk("t5_pre_1FF", 32'(rd), 32'h1234);
    do_reset();
    repeat (20) @(negedge clk);
    do_reset();
    wait_ready(n, out_nz);
    $display("sweep5: busy cycles %0d", n);
    chk("t5_busy_len", 32'(n), 32'd64);
    read_word(9'h03F, rd);
    chk("t5_03F", 32'(rd), 32'h0000);
    read_word(9'h040, rd);
    chk("t5_040", 32'(rd), 32'h0000);
    read_word(9'h1FF, rd);
    chk("t5_1FF", 32'(rd), 32'h0000);

    // 6: bank-edge addresses hold their own values.
    write_word(9'h03F, 16'h0001);
    write_word(9'h040, 16'h0002);
    write_word(9'h1FF, 16'h0003);
    read_word(9'h03F, rd);
    $display("t6: read 03F -> %h", rd);
    chk("t6_03F", 32'(rd), 32'h0001);
    read_word(9'h040, rd);
    $display("t6: read 040 -> %h", rd);
    chk("t6_040", 32'(rd), 32'h0002);
    read_word(9'h1FF, rd);
    $display("t6: read 1FF -> %h", rd);
    chk("t6_1FF", 32'(rd), 32'h0003);
    read_word(9'h000, rd);
    chk("t6_000_zero", 32'(rd), 32'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
